// File: rtl/iob_dma_buffered.sv
// rtl/iob_dma_buffered.sv - buffered memory-to-memory DMA with FIFO-decoupled read and write sides
module iob_dma_buffered #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int FIFO_AW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                c_valid,
    input  logic [2:0]          c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_wstrb,
    output logic [DATA_W-1:0]   c_rdata,
    output logic                c_ready,
    output logic                a_valid,
    output logic [ADDR_W-1:0]   a_addr,
    output logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W/8-1:0] a_wstrb,
    input  logic [DATA_W-1:0]   a_rdata,
    input  logic                a_ready,
    output logic                b_valid,
    output logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W/8-1:0] b_wstrb,
    input  logic [DATA_W-1:0]   b_rdata,
    input  logic                b_ready,
    output logic                irq
);
    localparam int STRB_W = DATA_W / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int DEPTH  = 2 ** FIFO_AW;

    typedef enum logic {IDLE, XFER} state_t;
    state_t state;

    logic [ADDR_W-1:0]  addr_a, addr_b;
    logic [LEN_W-1:0]   length;
    logic               dir;
    logic               done;

    logic               rd_valid;
    logic [ADDR_W-1:0]  rd_addr;
    logic [LEN_W-1:0]   rd_rem;
    logic [ADDR_W-1:0]  wr_addr;
    logic [LEN_W-1:0]   wr_rem;
    logic [STRB_W-1:0]  last_strb;

    logic [DATA_W-1:0]  fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count, count_next;

    logic               busy, cfg_wr, cfg_rd, run_req;
    logic               src_ready, dst_ready, rd_ack, wr_ack, wr_valid;
    logic [DATA_W-1:0]  src_rdata, wr_data, rd_mux;
    logic [STRB_W-1:0]  wr_strb, run_mask;
    logic [LEN_W:0]     len_ext;
    logic [LEN_W-1:0]   n_beats;
    logic [SHIFT-1:0]   len_tail;
    logic [ADDR_W-1:0]  src_start, dst_start;

    assign busy    = (state == XFER);
    assign cfg_wr  = c_valid && (c_wstrb != '0);
    assign cfg_rd  = c_valid && (c_wstrb == '0);
    assign run_req = cfg_wr && (c_addr == 3'd4) && c_wdata[0] && !busy;

    assign src_ready = dir ? b_ready : a_ready;
    assign dst_ready = dir ? a_ready : b_ready;
    assign src_rdata = dir ? b_rdata : a_rdata;

    // The write side is simply "FIFO non-empty"; head data and pointers are all registers.
    assign wr_valid   = (count != '0);
    assign wr_data    = wr_valid ? fifo_mem[rd_ptr] : '0;
    assign wr_strb    = !wr_valid ? '0 : (wr_rem == LEN_W'(1)) ? last_strb : '1;
    assign rd_ack     = rd_valid && src_ready;
    assign wr_ack     = wr_valid && dst_ready;
    assign count_next = count + {{FIFO_AW{1'b0}}, rd_ack} - {{FIFO_AW{1'b0}}, wr_ack};

    assign len_ext   = {1'b0, length} + (LEN_W+1)'(STRB_W - 1);
    assign n_beats   = LEN_W'(len_ext >> SHIFT);
    assign len_tail  = length[SHIFT-1:0];
    assign src_start = dir ? {addr_b[ADDR_W-1:SHIFT], {SHIFT{1'b0}}}
                           : {addr_a[ADDR_W-1:SHIFT], {SHIFT{1'b0}}};
    assign dst_start = dir ? {addr_a[ADDR_W-1:SHIFT], {SHIFT{1'b0}}}
                           : {addr_b[ADDR_W-1:SHIFT], {SHIFT{1'b0}}};

    always_comb begin
        run_mask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            run_mask[i] = (len_tail == '0) || (SHIFT'(i) < len_tail);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (c_addr)
            3'd0:    rd_mux = DATA_W'(addr_a);
            3'd1:    rd_mux = DATA_W'(addr_b);
            3'd2:    rd_mux = DATA_W'(length);
            3'd3:    rd_mux = DATA_W'(dir);
            3'd5:    rd_mux = DATA_W'({done, busy});
            default: rd_mux = '0;
        endcase
    end

    assign a_valid = dir ? wr_valid : rd_valid;
    assign a_addr  = dir ? wr_addr  : rd_addr;
    assign a_wdata = dir ? wr_data  : '0;
    assign a_wstrb = dir ? wr_strb  : '0;
    assign b_valid = dir ? rd_valid : wr_valid;
    assign b_addr  = dir ? rd_addr  : wr_addr;
    assign b_wdata = dir ? '0       : wr_data;
    assign b_wstrb = dir ? '0       : wr_strb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_a    <= '0;
            addr_b    <= '0;
            length    <= '0;
            dir       <= 1'b0;
            done      <= 1'b0;
            irq       <= 1'b0;
            c_ready   <= 1'b0;
            c_rdata   <= '0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            rd_rem    <= '0;
            wr_addr   <= '0;
            wr_rem    <= '0;
            last_strb <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            c_ready <= c_valid;
            c_rdata <= cfg_rd ? rd_mux : '0;
            irq     <= 1'b0;

            if (cfg_wr && !busy) begin
                case (c_addr)
                    3'd0:    addr_a <= ADDR_W'(c_wdata);
                    3'd1:    addr_b <= ADDR_W'(c_wdata);
                    3'd2:    length <= LEN_W'(c_wdata);
                    3'd3:    dir    <= c_wdata[0];
                    default: ;
                endcase
            end
            if (cfg_rd && c_addr == 3'd5) begin
                done <= 1'b0;
            end

            if (rd_ack) begin
                fifo_mem[wr_ptr] <= src_rdata;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (wr_ack) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;

            case (state)
                IDLE: begin
                    if (run_req) begin
                        if (length == '0) begin
                            done <= 1'b1;
                            irq  <= 1'b1;
                        end else begin
                            done      <= 1'b0;
                            state     <= XFER;
                            rd_valid  <= 1'b1;
                            rd_addr   <= src_start;
                            rd_rem    <= n_beats - 1'b1;
                            wr_addr   <= dst_start;
                            wr_rem    <= n_beats;
                            last_strb <= run_mask;
                        end
                    end
                end
                XFER: begin
                    if (rd_ack) begin
                        rd_addr <= rd_addr + ADDR_W'(STRB_W);
                    end
                    // Issue only if the slot after this edge fits: no read in flight, room in FIFO.
                    if ((!rd_valid || rd_ack) && rd_rem != '0 &&
                        count_next < (FIFO_AW+1)'(DEPTH)) begin
                        rd_valid <= 1'b1;
                        rd_rem   <= rd_rem - 1'b1;
                    end else if (rd_ack) begin
                        rd_valid <= 1'b0;
                    end
                    if (wr_ack) begin
                        wr_addr <= wr_addr + ADDR_W'(STRB_W);
                        wr_rem  <= wr_rem - 1'b1;
                        if (wr_rem == LEN_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            irq   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
